ppm16_rx_byte_fifo: RTL and testbench

//  Downstream stage of the 16-PPM demodulator. Consumes 4-bit symbols (din_valid/din) and packet_detected.

---
 rtl/ppm16_rx_byte_fifo_pkg.sv | 16 +
 rtl/ppm16_rx_byte_fifo_sync_fifo.sv | 51 +++++
 rtl/ppm16_rx_byte_fifo.sv | 83 ++++++++
 tb/tb_ppm16_rx_byte_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ppm16_rx_byte_fifo_pkg.sv
// ppm16_rx_byte_fifo_pkg: shared widths, FIFO entry layout and log2 helper for the PPM16 byte FIFO
package ppm16_rx_byte_fifo_pkg;
  localparam int PPM16_SYM_W = 4;
  localparam int PPM16_BYTE_W = 8;
  localparam int PPM16_ENTRY_W = PPM16_BYTE_W + 1;
  typedef struct packed {
    logic sop;
    logic [PPM16_BYTE_W-1:0] data;
  } fifo_entry_t;
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/ppm16_rx_byte_fifo_sync_fifo.sv
// ppm16_sync_fifo: synchronous first-word-fall-through FIFO; head output gated to zero while empty
module ppm16_sync_fifo
  import ppm16_rx_byte_fifo_pkg::*;
#(
  parameter int WIDTH = PPM16_ENTRY_W,
  parameter int DEPTH = 16,
  parameter int ADDR_W = ceil_log2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              wr_drop
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  assign empty = count == '0;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign rd_acc = rd_en & ~empty;
  // a full FIFO still accepts a write when the head is popped in the same cycle
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_drop = wr_en & ~wr_acc;
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // storage is deliberately not reset; the output gate hides stale contents
  always_ff @(posedge clk) begin
    if (wr_acc && !clear) mem[wr_ptr] <= wr_data;
  end
  // pointers wrap naturally at DEPTH; count carries one extra bit to tell full from empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    end
  end
endmodule

// File: rtl/ppm16_rx_byte_fifo.sv
// ppm16_rx_byte_fifo: packs PPM16 symbol pairs into sop-tagged bytes and buffers them; PPM16_FIFO_OVF_COUNT_EN adds ovf_count
module ppm16_rx_byte_fifo
  import ppm16_rx_byte_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = ceil_log2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    packet_detected,
  input  logic                    din_valid,
  input  logic [PPM16_SYM_W-1:0]  din,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [PPM16_BYTE_W-1:0] rd_data,
  output logic                    rd_sop,
  output logic [ADDR_W:0]         count,
  output logic                    full,
  output logic                    overflow
`ifdef PPM16_FIFO_OVF_COUNT_EN
  ,
  output logic [7:0]              ovf_count
`endif
);
  logic half, sop_pending;
  logic [PPM16_SYM_W-1:0] lo;
  logic wr_en, empty, wr_drop;
  fifo_entry_t wr_entry, rd_entry;
  // a pending lo nibble is written either when its hi nibble arrives or, zero-padded, when a new packet starts
  assign wr_en = half & (packet_detected | din_valid);
  assign wr_entry = {sop_pending, packet_detected ? 4'h0 : din, lo};
  assign rd_valid = ~empty;
  assign rd_data = rd_entry.data;
  assign rd_sop = rd_entry.sop;
  ppm16_sync_fifo #(.WIDTH(PPM16_ENTRY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk(clk),
    .resetn(resetn),
    .clear(clear),
    .wr_en(wr_en),
    .wr_data(wr_entry),
    .rd_en(rd_ready),
    .rd_data(rd_entry),
    .count(count),
    .full(full),
    .empty(empty),
    .wr_drop(wr_drop)
  );
  // nibble packer and start-of-packet tracking; a new packet may take din as its first lo nibble
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      half <= 1'b0;
      sop_pending <= 1'b0;
      lo <= '0;
    end else if (clear) begin
      half <= 1'b0;
      sop_pending <= 1'b0;
      lo <= '0;
    end else if (packet_detected) begin
      sop_pending <= 1'b1;
      half <= din_valid;
      if (din_valid) lo <= din;
    end else if (din_valid) begin
      half <= ~half;
      if (!half) lo <= din;
      else sop_pending <= 1'b0;
    end
  end
  // sticky record of any byte dropped on a full FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (wr_drop) overflow <= 1'b1;
  end
`ifdef PPM16_FIFO_OVF_COUNT_EN
  // saturating count of dropped bytes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_count <= '0;
    else if (clear) ovf_count <= '0;
    else if (wr_drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_ppm16_rx_byte_fifo.sv
// tb_ppm16_rx_byte_fifo: table-driven and sequence checks of the PPM16 byte packer and FIFO
module tb_ppm16_rx_byte_fifo;
  logic clk = 0, resetn = 0, clear = 0, packet_detected = 0, din_valid = 0, rd_ready = 0;
  logic [3:0] din = 0;
  logic rd_valid, rd_sop, full, overflow;
  logic [7:0] rd_data;
  logic [4:0] count;
`ifdef PPM16_FIFO_OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif
  int n_vec = 0, n_err = 0;

  typedef struct {
    logic c, p, v;
    logic [3:0] d;
    logic r;
    logic ev;
    logic [7:0] ed;
    logic es;
    int ec;
  } vec_t;
  vec_t tbl[$];

  ppm16_rx_byte_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk),
    .resetn(resetn),
    .clear(clear),
    .packet_detected(packet_detected),
    .din_valid(din_valid),
    .din(din),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_sop(rd_sop),
    .count(count),
    .full(full),
    .overflow(overflow)
`ifdef PPM16_FIFO_OVF_COUNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic p, input logic v, input logic [3:0] d, input logic r);
    clear = c;
    packet_detected = p;
    din_valid = v;
    din = d;
    rd_ready = r;
    @(posedge clk);
    #1;
    clear = 0;
    packet_detected = 0;
    din_valid = 0;
    rd_ready = 0;
  endtask

  function automatic vec_t mk(logic c, logic p, logic v, logic [3:0] d, logic r, logic ev, logic [7:0] ed, logic es, int ec);
    vec_t t;
    t.c = c; t.p = p; t.v = v; t.d = d; t.r = r;
    t.ev = ev; t.ed = ed; t.es = es; t.ec = ec;
    return t;
  endfunction

  function automatic logic [7:0] bval(int i);
    logic [3:0] h;
    h = 4'(i);
    return {h, ~h};
  endfunction

  task automatic wr_byte(input logic [7:0] b, input logic r);
    step(0, 0, 1, b[3:0], 0);
    step(0, 0, 1, b[7:4], r);
  endtask

  initial begin
    // packet 1: 3,A,5,C
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h3, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'hA, 0, 1, 8'hA3, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'h5, 0, 1, 8'hA3, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'hC, 0, 1, 8'hA3, 1, 2));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 8'hC5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 8'h00, 0, 0));
    // packet 2: 1,2,7 then new packet flushes 07; next packet 6,8
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h1, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h2, 0, 1, 8'h21, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'h7, 0, 1, 8'h21, 1, 1));
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 1, 8'h21, 1, 2));
    tbl.push_back(mk(0, 0, 1, 4'h6, 0, 1, 8'h21, 1, 2));
    tbl.push_back(mk(0, 0, 1, 4'h8, 0, 1, 8'h21, 1, 3));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 8'h07, 0, 2));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 8'h86, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 8'h00, 0, 0));
    // packet_detected with din_valid while half=1, lo=4
    tbl.push_back(mk(0, 1, 0, 4'h0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'h4, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 4'h9, 0, 1, 8'h04, 1, 1));
    tbl.push_back(mk(0, 0, 1, 4'hB, 0, 1, 8'h04, 1, 2));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 1, 8'hB9, 1, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 8'h00, 0, 0));
    // rd_ready while empty is ignored
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0, 8'h00, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_sop", rd_sop, 0);
    chk("reset count", count, 0);
    chk("reset full", full, 0);
    chk("reset overflow", overflow, 0);
    resetn = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].p, tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("v%0d rd_valid", i), rd_valid, tbl[i].ev);
      chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].ed);
      chk($sformatf("v%0d rd_sop", i), rd_sop, tbl[i].es);
      chk($sformatf("v%0d count", i), count, tbl[i].ec);
    end

    // fill past DEPTH with no reads
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      wr_byte(bval(i), 0);
      if (i == 15) begin
        chk("fill16 full", full, 1);
        chk("fill16 count", count, 16);
        chk("fill16 overflow", overflow, 0);
      end
      if (i == 16) begin
        chk("fill17 overflow", overflow, 1);
        chk("fill17 count", count, 16);
      end
    end
    chk("fill head data", rd_data, bval(0));
    chk("fill head sop", rd_sop, 1);
    chk("fill full", full, 1);
`ifdef PPM16_FIFO_OVF_COUNT_EN
    chk("ovf_count", ovf_count, 2);
`endif

    // drain to 5 entries, leave half a byte pending, then clear (with a competing symbol)
    for (int k = 0; k < 11; k++) step(0, 0, 0, 0, 1);
    chk("drain count", count, 5);
    chk("drain head", rd_data, bval(11));
    chk("drain overflow sticky", overflow, 1);
    step(0, 0, 1, 4'h6, 0);
    chk("half count", count, 5);
    step(1, 0, 1, 4'h7, 0);
    chk("clear count", count, 0);
    chk("clear rd_valid", rd_valid, 0);
    chk("clear rd_data", rd_data, 0);
    chk("clear overflow", overflow, 0);
    chk("clear full", full, 0);
    wr_byte(8'hD2, 0);
    chk("post-clear count", count, 1);
    chk("post-clear data", rd_data, 8'hD2);
    chk("post-clear sop", rd_sop, 0);

    // full FIFO with simultaneous write and read
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) wr_byte(bval(i), 0);
    chk("full2 count", count, 16);
    wr_byte(bval(16), 1);
    chk("wr+rd count", count, 16);
    chk("wr+rd overflow", overflow, 0);
    chk("wr+rd full", full, 1);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("order %0d data", k), rd_data, bval(k));
      chk($sformatf("order %0d sop", k), rd_sop, 0);
      step(0, 0, 0, 0, 1);
    end
    chk("final count", count, 0);
    chk("final rd_valid", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
